uart_receiver: RTL and testbench

Serial-to-parallel UART receive stage; the counterpart of the team's `sender` transmitter, on the far end of the same 8N1 serial link. Oversamples the asynchronous `rx` pin with the system clock, validates the start bit at mid-bit, samples 8 data bits LSB first and checks the stop bit. Delivers each good byte with a one-cycle valid strobe to the downstream game/command logic. Reports framing errors separately.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_receiver_if.sv | 28 ++
 rtl/uart_receiver_bit_synchronizer.sv | 24 ++
 rtl/uart_receiver.sv | 121 ++++++++++++
 tb/tb_uart_receiver.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: constants and types shared by both ends of the 8N1 serial link.
// The transmitter imports the same bit timing so the two ends stay matched.
package uart_pkg;

   localparam int CLOCK_PER_BIT      = 2604;
   localparam int HALF_CLOCK_PER_BIT = CLOCK_PER_BIT / 2;
   localparam int FRAME_BITS         = 8;
   localparam int CNT_W              = 12;
   localparam int IDX_W              = $clog2(FRAME_BITS);

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } rx_state_e;

   typedef logic [FRAME_BITS-1:0] frame_t;
   typedef logic [CNT_W-1:0]      bit_cnt_t;
   typedef logic [IDX_W-1:0]      bit_idx_t;

endpackage

// File: rtl/uart_receiver_if.sv
// uart_receiver_if: serial line plus the byte/strobe/status bundle
// seen by the logic downstream of the receiver.
interface uart_receiver_if;
   import uart_pkg::*;

   logic   rx;
   frame_t received;
   logic   received_valid;
   logic   frame_error;
   logic   busy;

   modport master (
      output rx,
      input  received,
      input  received_valid,
      input  frame_error,
      input  busy
   );

   modport slave (
      input  rx,
      output received,
      output received_valid,
      output frame_error,
      output busy
   );

endinterface

// File: rtl/uart_receiver_bit_synchronizer.sv
// bit_synchronizer: 2-flop synchronizer for an asynchronous input.
// Reset value is chosen by the caller (idle level of the input).
module bit_synchronizer #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clock,
   input  logic reset,
   input  logic d_i,
   output logic q_o
);

   logic [1:0] sync_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync_q <= {2{RESET_VAL}};
      end else begin
         sync_q <= {sync_q[0], d_i};
      end
   end

   assign q_o = sync_q[1];

endmodule

// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 serial receive stage with mid-bit sampling.
// Delivers good bytes with a one-cycle strobe; framing errors pulse separately.
module uart_receiver
   import uart_pkg::*;
#(
   parameter int clock_per_bit      = CLOCK_PER_BIT,
   parameter int half_clock_per_bit = HALF_CLOCK_PER_BIT
) (
   input  logic           clock,
   input  logic           reset,
   uart_receiver_if.slave bus
);

   localparam bit_cnt_t HALF_LAST = CNT_W'(half_clock_per_bit - 1);
   localparam bit_cnt_t BIT_LAST  = CNT_W'(clock_per_bit - 1);
   localparam bit_idx_t IDX_LAST  = IDX_W'(FRAME_BITS - 1);

   logic      rx_s;
   logic      rx_prev_q;
   rx_state_e state_q, state_d;
   bit_cnt_t  cnt_q, cnt_d;
   bit_idx_t  idx_q, idx_d;
   frame_t    shift_q, shift_d;
   frame_t    recv_q, recv_d;
   logic      valid_q, valid_d;
   logic      ferr_q, ferr_d;

   bit_synchronizer #(
      .RESET_VAL (1'b1)
   ) u_rx_sync (
      .clock (clock),
      .reset (reset),
      .d_i   (bus.rx),
      .q_o   (rx_s)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rx_prev_q <= 1'b1;
         state_q   <= IDLE;
         cnt_q     <= '0;
         idx_q     <= '0;
         shift_q   <= '0;
         recv_q    <= '0;
         valid_q   <= 1'b0;
         ferr_q    <= 1'b0;
      end else begin
         rx_prev_q <= rx_s;
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         shift_q   <= shift_d;
         recv_q    <= recv_d;
         valid_q   <= valid_d;
         ferr_q    <= ferr_d;
      end
   end

   // counter restarts from zero on every state change
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + bit_cnt_t'(1);
      idx_d   = idx_q;
      shift_d = shift_q;
      recv_d  = recv_q;
      valid_d = 1'b0;
      ferr_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (rx_prev_q && !rx_s) begin
               state_d = START;
            end
         end
         START: begin
            if (cnt_q == HALF_LAST) begin
               cnt_d = '0;
               idx_d = '0;
               if (!rx_s) begin
                  state_d = DATA;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         DATA: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d          = '0;
               shift_d[idx_q] = rx_s;
               if (idx_q == IDX_LAST) begin
                  state_d = STOP;
               end else begin
                  idx_d = idx_q + bit_idx_t'(1);
               end
            end
         end
         STOP: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d   = '0;
               state_d = IDLE;
               if (rx_s) begin
                  recv_d  = shift_q;
                  valid_d = 1'b1;
               end else begin
                  ferr_d = 1'b1;
               end
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   assign bus.received       = recv_q;
   assign bus.received_valid = valid_q;
   assign bus.frame_error    = ferr_q;
   assign bus.busy           = (state_q != IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: directed frames with a scoreboard of expected strobes.
// Short bit period keeps the run small; timing is checked to the edge.
module tb_uart_receiver;
   import uart_pkg::*;

   localparam int CPB   = 32;
   localparam int HALF  = 16;
   localparam int CLK_T = 100;
   localparam int BIT_T = CPB * CLK_T;
   localparam int OFS   = 20;

   typedef struct {
      logic       err;
      logic [7:0] data;
      int         cyc;
   } exp_t;

   logic clock = 1'b0;
   logic reset = 1'b1;
   exp_t q[$];
   int cyc = 0;
   int n_vec = 0;
   int n_err = 0;
   logic [7:0] last_good = 8'h00;
   logic pulse_last = 1'b0;

   uart_receiver_if bus();

   uart_receiver #(
      .clock_per_bit      (CPB),
      .half_clock_per_bit (HALF)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #(CLK_T/2) clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int req);
      n_vec++;
      if (act != req) begin
         n_err++;
         $display("FAIL %s: actual %0h required %0h (cycle %0d)",
                  name, act, req, cyc);
      end
   endtask

   task automatic send(input logic [7:0] b, input logic stop,
                       input int bit_t, input logic align,
                       input logic timed);
      exp_t e;
      if (align) begin
         @(posedge clock);
         #(OFS);
      end
      bus.rx = 1'b0;
      e.err  = !stop;
      e.data = stop ? b : last_good;
      e.cyc  = timed ? cyc + 3 + HALF + 9 * CPB : -1;
      if (stop) last_good = b;
      q.push_back(e);
      #(bit_t);
      for (int i = 0; i < 8; i++) begin
         bus.rx = b[i];
         #(bit_t);
      end
      bus.rx = stop;
      #(bit_t);
   endtask

   task automatic idle(input int n);
      bus.rx = 1'b1;
      repeat (n) @(posedge clock);
   endtask

   always @(negedge clock) begin : mon
      exp_t e;
      if (pulse_last) begin
         chk("pulse_width",
             int'(bus.received_valid | bus.frame_error), 0);
      end
      pulse_last = bus.received_valid | bus.frame_error;
      if (bus.received_valid || bus.frame_error) begin
         chk("valid_ferr_exclusive",
             int'(bus.received_valid & bus.frame_error), 0);
         if (q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_pulse: actual valid=%0b ferr=%0b data=%0h required no pulse",
                     bus.received_valid, bus.frame_error, bus.received);
         end else begin
            e = q.pop_front();
            chk("pulse_kind_ferr", int'(bus.frame_error), int'(e.err));
            chk("received", int'(bus.received), int'(e.data));
            if (e.cyc >= 0) chk("pulse_cycle", cyc, e.cyc);
         end
      end
   end

   initial begin
      #(5000 * CPB * CLK_T);
      $display("FAIL watchdog: actual timeout required finish");
      $fatal(1);
   end

   initial begin
      int hi;
      bus.rx = 1'b1;
      #(OFS);
      chk("reset_received", int'(bus.received), 0);
      chk("reset_valid", int'(bus.received_valid), 0);
      chk("reset_ferr", int'(bus.frame_error), 0);
      chk("reset_busy", int'(bus.busy), 0);
      repeat (4) @(posedge clock);
      #(OFS);
      reset = 1'b0;
      idle(8);

      send(8'h55, 1'b1, BIT_T, 1'b1, 1'b1);
      idle(CPB);

      // stop bit low, then the line stays low (break)
      send(8'hC4, 1'b0, BIT_T, 1'b1, 1'b1);
      hi = 0;
      for (int i = 0; i < 3 * CPB; i++) begin
         @(negedge clock);
         if (bus.busy) hi++;
      end
      chk("break_busy_cycles", hi, 0);
      idle(2 * CPB);

      send(8'hA3, 1'b1, BIT_T, 1'b1, 1'b1);
      send(8'h00, 1'b1, BIT_T, 1'b0, 1'b1);
      idle(CPB);

      @(posedge clock);
      #(OFS);
      bus.rx = 1'b0;
      hi = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clock);
         if (bus.busy) hi++;
         @(posedge clock);
         #(OFS);
         if (i == 5) bus.rx = 1'b1;
      end
      chk("glitch_busy_cycles", hi, HALF);
      idle(CPB);
      send(8'h7E, 1'b1, BIT_T, 1'b1, 1'b1);
      idle(CPB);

      // abort a frame of zeros during data bit 4
      @(posedge clock);
      #(OFS);
      bus.rx = 1'b0;
      repeat (5 * CPB + 10) @(posedge clock);
      #(OFS);
      chk("pre_reset_busy", int'(bus.busy), 1);
      reset = 1'b1;
      #1;
      chk("midreset_received", int'(bus.received), 0);
      chk("midreset_valid", int'(bus.received_valid), 0);
      chk("midreset_ferr", int'(bus.frame_error), 0);
      chk("midreset_busy", int'(bus.busy), 0);
      last_good = 8'h00;
      bus.rx = 1'b1;
      repeat (3) @(posedge clock);
      #(OFS);
      reset = 1'b0;
      idle(8);
      send(8'h3C, 1'b1, BIT_T, 1'b1, 1'b1);
      idle(CPB);

      send(8'h96, 1'b1, (BIT_T * 103) / 100, 1'b1, 1'b0);
      idle(CPB);
      send(8'h96, 1'b1, (BIT_T * 97) / 100, 1'b1, 1'b0);
      idle(CPB);

      for (int i = 0; i < 20 * CPB && q.size() != 0; i++) begin
         @(posedge clock);
      end
      chk("pending_expected", q.size(), 0);
      idle(2 * CPB);
      chk("final_received", int'(bus.received), 8'h96);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
